// File: rtl/rf_port_sched_if.sv
// Bundle of the write-port scheduler's pipeline, multi-cycle unit and register
// file signals. The slave modport is the scheduler's view of the bundle.
interface rf_port_sched_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mc_valid, mc_rd, mc_data,
    input  iss_valid, iss_rd,
    input  id_valid, id_rs1, id_rs2, id_rd,
    output mc_ready, rf_we, rf_waddr, rf_wdata, stall
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output mc_valid, mc_rd, mc_data,
    output iss_valid, iss_rd,
    output id_valid, id_rs1, id_rs2, id_rd,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, stall
  );
endinterface

// File: rtl/rf_port_sched.sv
// Register-file write-port scheduler: WB writes take the single port, while
// multi-cycle results wait in a 2-entry FIFO and drain on idle WB cycles.
// A busy scoreboard stalls ID on pending multi-cycle destinations, and an age
// counter stalls the pipeline when the FIFO head has waited too long.
module rf_port_sched #(
  parameter int STARVE_MAX = 3,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  rf_port_sched_if.slave bus
);
  localparam logic [1:0] DEPTH     = 2'(FIFO_DEPTH);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  count_q, count_d, fill;
  logic [4:0]  e0_rd_q, e0_rd_d, e1_rd_q, e1_rd_d;
  logic [31:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  age_q, age_d;

  logic wb_claim, head_valid, pop, enq, hazard, starve;

  assign head_valid   = (count_q != 2'd0);
  assign wb_claim     = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign pop          = head_valid && !wb_claim;
  // Ready comes from registered occupancy; held high while reset discards state.
  assign bus.mc_ready = rst || (count_q < DEPTH);
  assign enq          = bus.mc_valid && bus.mc_ready;

  // FIFO next state: entry 0 is the head; a pop shifts entry 1 down first.
  always_comb begin
    e0_rd_d   = e0_rd_q;
    e0_data_d = e0_data_q;
    e1_rd_d   = e1_rd_q;
    e1_data_d = e1_data_q;
    fill      = count_q;
    if (pop) begin
      e0_rd_d   = e1_rd_q;
      e0_data_d = e1_data_q;
      fill      = count_q - 2'd1;
    end
    if (enq) begin
      if (fill == 2'd0) begin
        e0_rd_d   = bus.mc_rd;
        e0_data_d = bus.mc_data;
      end else begin
        e1_rd_d   = bus.mc_rd;
        e1_data_d = bus.mc_data;
      end
      fill = fill + 2'd1;
    end
    count_d = fill;
  end

  // Busy scoreboard: clear on head pop, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[e0_rd_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Head age: counts unpopped cycles of a valid head, saturating at 15.
  always_comb begin
    age_d = age_q;
    if (pop || !head_valid) age_d = 4'd0;
    else if (age_q != 4'hF) age_d = age_q + 4'd1;
  end

  assign hazard = bus.id_valid &&
                  ((busy_q[bus.id_rs1] && (bus.id_rs1 != 5'd0)) ||
                   (busy_q[bus.id_rs2] && (bus.id_rs2 != 5'd0)) ||
                   (busy_q[bus.id_rd]  && (bus.id_rd  != 5'd0)));
  assign starve    = (age_q >= STARVE_LIM);
  assign bus.stall = !rst && (hazard || starve);

  // Write-port mux: WB first, then the FIFO head (suppressed while in reset).
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (wb_claim) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.wb_rd;
      bus.rf_wdata = bus.wb_data;
    end else if (head_valid && !rst) begin
      bus.rf_we    = (e0_rd_q != 5'd0);
      bus.rf_waddr = e0_rd_q;
      bus.rf_wdata = e0_data_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      e0_rd_q   <= 5'd0;
      e0_data_q <= 32'd0;
      e1_rd_q   <= 5'd0;
      e1_data_q <= 32'd0;
      busy_q    <= 32'd0;
      age_q     <= 4'd0;
    end else begin
      count_q   <= count_d;
      e0_rd_q   <= e0_rd_d;
      e0_data_q <= e0_data_d;
      e1_rd_q   <= e1_rd_d;
      e1_data_q <= e1_data_d;
      busy_q    <= busy_d;
      age_q     <= age_d;
    end
  end
endmodule

// File: tb/tb_rf_port_sched.sv
// Scenario bench for rf_port_sched: each task drives one feature and checks
// outputs inline; every expected register-file write is queued and matched
// by the write monitor when rf_we is seen.
module tb_rf_port_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_port_sched_if bus();
  rf_port_sched #(.STARVE_MAX(3), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0;
  int failures = 0;

  // Write monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got addr=%0d data=%h required no write", bus.rf_waddr, bus.rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.rf_waddr, bus.rf_wdata} !== {mon_e.a, mon_e.d}) begin
          failures++;
          $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                   bus.rf_waddr, bus.rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.mc_valid = 0; bus.mc_rd = 0; bus.mc_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); #3;
    checks++; if (bus.mc_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b required 1", bus.mc_ready); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got %b required 0", bus.stall); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b required 0", bus.rf_we); end
    tick();
    idle(); bus.wb_valid = 1; bus.wb_rd = 4; bus.wb_data = 32'hBEEF;
    exp_q.push_back('{5'd4, 32'hBEEF}); #3;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4) begin failures++; $display("FAIL rst_wb_path got we=%b addr=%0d required we=1 addr=4", bus.rf_we, bus.rf_waddr); end
    tick();
    rst = 0; idle(); bus.id_valid = 1; bus.id_rs1 = 4; #3;
    checks++; if (bus.mc_ready !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL post_rst got ready=%b stall=%b required ready=1 stall=0", bus.mc_ready, bus.stall); end
    tick();
  endtask

  task automatic test_hazard();
    idle(); bus.iss_valid = 1; bus.iss_rd = 5; tick();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5;
    bus.mc_valid = 1; bus.mc_rd = 5; bus.mc_data = 32'h1234;
    exp_q.push_back('{5'd5, 32'h1234}); #3;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL hz_rs1 stall got %b required 1", bus.stall); end
    tick();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5; #3;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234) begin failures++; $display("FAIL hz_drain got we=%b addr=%0d data=%h required we=1 addr=5 data=1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
    idle(); bus.id_valid = 1; bus.id_rs1 = 5; #3;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_release stall got %b required 0", bus.stall); end
    tick();
    idle(); bus.iss_valid = 1; bus.iss_rd = 6; tick();
    idle(); bus.id_valid = 1; bus.id_rs2 = 6; #3;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL hz_rs2 stall got %b required 1", bus.stall); end
    bus.id_rs2 = 0; bus.id_rd = 6; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL hz_rd stall got %b required 1", bus.stall); end
    bus.id_valid = 0; #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_noid stall got %b required 0", bus.stall); end
    tick();
    idle(); bus.mc_valid = 1; bus.mc_rd = 6; bus.mc_data = 32'h66;
    exp_q.push_back('{5'd6, 32'h66}); tick();
    idle(); tick();
    idle(); bus.id_valid = 1; bus.id_rd = 6; #3;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_rd_clear stall got %b required 0", bus.stall); end
    tick();
  endtask

  task automatic test_priority();
    idle(); bus.mc_valid = 1; bus.mc_rd = 7; bus.mc_data = 32'h7777; tick();
    idle(); bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'hAAAA;
    exp_q.push_back('{5'd3, 32'hAAAA});
    exp_q.push_back('{5'd7, 32'h7777}); #3;
    checks++; if (bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'hAAAA) begin failures++; $display("FAIL prio_wb got addr=%0d data=%h required addr=3 data=aaaa", bus.rf_waddr, bus.rf_wdata); end
    tick();
    idle(); #3;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin failures++; $display("FAIL prio_fifo got we=%b addr=%0d required we=1 addr=7", bus.rf_we, bus.rf_waddr); end
    tick();
    idle(); bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h1; #3;
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wdata !== 32'h0) begin failures++; $display("FAIL prio_wb_r0 got we=%b data=%h required we=0 data=0", bus.rf_we, bus.rf_wdata); end
    tick();
  endtask

  task automatic test_starve();
    for (int c = 1; c <= 6; c++) begin
      idle();
      bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h100 + c;
      exp_q.push_back('{5'd1, 32'h100 + c});
      bus.mc_valid = 1;
      bus.mc_rd   = (c == 1) ? 5'd10 : (c == 2) ? 5'd11 : 5'd12;
      bus.mc_data = (c == 1) ? 32'hA0 : (c == 2) ? 32'hB0 : 32'hC0;
      #3;
      checks++; if (bus.mc_ready !== (c <= 2)) begin failures++; $display("FAIL stv_ready c=%0d got %b required %b", c, bus.mc_ready, (c <= 2)); end
      if (c >= 3) begin
        checks++; if (bus.stall !== (c >= 5)) begin failures++; $display("FAIL stv_stall c=%0d got %b required %b", c, bus.stall, (c >= 5)); end
      end
      tick();
    end
    idle(); bus.mc_valid = 1; bus.mc_rd = 12; bus.mc_data = 32'hC0;
    exp_q.push_back('{5'd10, 32'hA0}); #3;
    checks++; if (bus.rf_waddr !== 5'd10 || bus.stall !== 1'b1 || bus.mc_ready !== 1'b0) begin failures++; $display("FAIL stv_pop1 got addr=%0d stall=%b ready=%b required addr=10 stall=1 ready=0", bus.rf_waddr, bus.stall, bus.mc_ready); end
    tick();
    idle(); bus.mc_valid = 1; bus.mc_rd = 12; bus.mc_data = 32'hC0;
    exp_q.push_back('{5'd11, 32'hB0}); #3;
    checks++; if (bus.rf_waddr !== 5'd11 || bus.stall !== 1'b0 || bus.mc_ready !== 1'b1) begin failures++; $display("FAIL stv_pop2 got addr=%0d stall=%b ready=%b required addr=11 stall=0 ready=1", bus.rf_waddr, bus.stall, bus.mc_ready); end
    tick();
    idle(); exp_q.push_back('{5'd12, 32'hC0}); #3;
    checks++; if (bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'hC0) begin failures++; $display("FAIL stv_pop3 got addr=%0d data=%h required addr=12 data=c0", bus.rf_waddr, bus.rf_wdata); end
    tick();
    idle(); tick();
  endtask

  task automatic test_rd0();
    idle(); bus.mc_valid = 1; bus.mc_rd = 0; bus.mc_data = 32'h55; tick();
    idle(); bus.id_valid = 1; #3;
    checks++; if (bus.rf_we !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL rd0_pop got we=%b stall=%b required we=0 stall=0", bus.rf_we, bus.stall); end
    tick();
    idle(); #3;
    checks++; if (bus.rf_wdata !== 32'h0 || bus.mc_ready !== 1'b1) begin failures++; $display("FAIL rd0_gone got data=%h ready=%b required data=0 ready=1", bus.rf_wdata, bus.mc_ready); end
    tick();
  endtask

  task automatic test_set_clear();
    idle(); bus.iss_valid = 1; bus.iss_rd = 9; tick();
    idle(); bus.mc_valid = 1; bus.mc_rd = 9; bus.mc_data = 32'h99; tick();
    idle(); bus.iss_valid = 1; bus.iss_rd = 9;
    exp_q.push_back('{5'd9, 32'h99}); #3;
    checks++; if (bus.rf_waddr !== 5'd9) begin failures++; $display("FAIL sc_pop got addr=%0d required 9", bus.rf_waddr); end
    tick();
    idle(); bus.id_valid = 1; bus.id_rs1 = 9; #3;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL sc_set_wins stall got %b required 1", bus.stall); end
    tick();
    idle(); bus.mc_valid = 1; bus.mc_rd = 9; bus.mc_data = 32'h9A;
    exp_q.push_back('{5'd9, 32'h9A}); tick();
    idle(); tick();
    idle(); bus.id_valid = 1; bus.id_rs1 = 9; #3;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL sc_clear stall got %b required 0", bus.stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); bus.iss_valid = 1; bus.iss_rd = 22; tick();
    for (int c = 0; c < 2; c++) begin
      idle(); bus.wb_valid = 1; bus.wb_rd = 2; bus.wb_data = 32'h201 + c;
      exp_q.push_back('{5'd2, 32'h201 + c});
      bus.mc_valid = 1; bus.mc_rd = 5'd20 + 5'(c); bus.mc_data = 32'hD0 + c;
      tick();
    end
    rst = 1; idle(); bus.id_valid = 1; bus.id_rs1 = 22; #3;
    checks++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL mid_rst got we=%b ready=%b stall=%b required we=0 ready=1 stall=0", bus.rf_we, bus.mc_ready, bus.stall); end
    tick();
    rst = 0; idle(); bus.id_valid = 1; bus.id_rs1 = 22; #3;
    checks++; if (bus.rf_we !== 1'b0 || bus.mc_ready !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL mid_after got we=%b ready=%b stall=%b required we=0 ready=1 stall=0", bus.rf_we, bus.mc_ready, bus.stall); end
    tick();
    idle(); tick(); tick();
  endtask

  initial begin
    rst = 1; idle(); tick();
    test_reset();
    test_hazard();
    test_priority();
    test_starve();
    test_rd0();
    test_set_clear();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_missing got %0d pending writes required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
